spi_fpga_master: RTL and testbench
==================================

# spi_fpga_master

Single-clock SPI master, the initiating end for the SPI_FPGA slave family. It accepts a parallel word on a start strobe and generates CS, SCLK and MOSI for any of the four CPHA/CPOL modes. It shifts in MISO and presents the received word with a one-cycle done pulse. It sits between user logic on IN_CLK and the off-chip or on-chip SPI slave pins.

## Interface
- CPHA, 1, clock phase: 0 = sample on leading edge; 1 = shift on leading edge, sample on trailing edge
- CPOL, 1, SCLK idle level
- PACK_LENGTH, 8, bits per package (≥2)
- PACK_BIT_SEQUENCE_TRANSMIT, 1, 1 = MSB sent first; 0 = LSB sent first
- PACK_BIT_SEQUENCE_RECEIVE, 1, 1 = first received bit lands in MSB; 0 = first received bit lands in LSB
- CLK_DIV, 2, SCLK half-period in IN_CLK cycles (H, ≥1)
- IN_CLK  in  1  system clock; all logic on its rising edge
- IN_RESET  in  1  synchronous, active-high reset
- IN_START  in  1  start request, sampled only when idle
- IN_TRANSMIT_DATA  in  PACK_LENGTH  word latched on accepted start
- MISO  in  1  serial data from slave
- SCLK  out  1  serial clock, registered
- MOSI  out  1  serial data to slave, registered
- CS  out  1  chip select, active low, registered
- OUT_BUSY  out  1  high from the cycle after start acceptance until the done cycle
- OUT_DONE  out  1  one-cycle pulse, end of transfer
- OUT_RECEIVE_DATA  out  PACK_LENGTH  last received word, held until next done

## Operation
- FSM: IDLE → SETUP → TRANSFER → HOLD → IDLE.
- IDLE: CS=1, SCLK=CPOL, MOSI=0. IN_START=1 latches IN_TRANSMIT_DATA, bit-reversed if TRANSMIT=0, into the TX shift register, then goes to SETUP.
- SETUP (H cycles): CS=0. If CPHA=0, MOSI presents the first bit on entry.
- TRANSFER: 2·PACK_LENGTH SCLK edges, one every H cycles. Edges alternate leading/trailing, starting with leading.
  - CPHA=0: capture MISO on leading edges. Drive the next bit on trailing edges, except the last one.
  - CPHA=1: drive the next bit on leading edges. Capture MISO on trailing edges.
- The MISO capture takes the value present in the IN_CLK cycle in which the sampling edge is registered. Captured bits shift into the RX register from the LSB side.
- HOLD (H cycles): SCLK=CPOL, CS still 0.
- Exit to IDLE: in the same cycle, CS=1, OUT_DONE=1, OUT_BUSY=0 and OUT_RECEIVE_DATA is updated. The update is the RX register, bit-reversed if RECEIVE=0.
- IN_START while busy is ignored, with no queueing.
- IN_START in the OUT_DONE cycle is accepted (back-to-back transfer), so CS is high for exactly 1 cycle.

## Timing
- Start sampled at cycle 0. CS falls at cycle 1.
- Edge k (k=1..2N, N=PACK_LENGTH) is registered at cycle 1+k·H.
- CS rises and OUT_DONE pulses at cycle 1+(2N+1)·H. For N=8, H=2 that is cycle 35.
- CS is low for (2N+1)·H cycles. The SCLK period is 2H.
- Reset values: CS=1, SCLK=CPOL, MOSI=0, OUT_BUSY=0, OUT_DONE=0, OUT_RECEIVE_DATA=0; FSM=IDLE; counters 0.
- Reset mid-transfer: outputs take reset values the next cycle, with no OUT_DONE pulse and no partial word published.
- MISO has no synchronizer; it is valid for a same-clock-domain slave or when H ≥ 2 with an external synchronizer.

## Structure
- Shared package spi_fpga_pkg holds:
  - FSM state encoding (IDLE, SETUP, TRANSFER, HOLD)
  - the flip_backwards bit-reversal function, shared with the slave
  - the edge-type constants
- Sub-module spi_fpga_sclk_gen holds the half-period counter and edge counter. It outputs a leading/trailing edge strobe and a last-edge flag, and the FSM and shift registers consume them.

## Test plan
- Mode CPHA=0/CPOL=0, N=8, H=2, MISO looped to MOSI, send 0xA5:
  - MOSI bits 1,0,1,0,0,1,0,1
  - OUT_RECEIVE_DATA=0xA5 and OUT_DONE at cycle 35
- Mode CPHA=1/CPOL=1, behavioral slave returns 0x3C, send 0xC3:
  - slave captures 0xC3
  - OUT_RECEIVE_DATA=0x3C
  - SCLK idles high before and after
- TRANSMIT=0, RECEIVE=0, loopback, send 0x01:
  - first MOSI bit is 1
  - OUT_RECEIVE_DATA=0x01
- IN_START pulsed at cycles 5 and 20 of an active transfer:
  - ignored
  - exactly one OUT_DONE
  - CS stays low continuously until done
- IN_RESET asserted at cycle 10 mid-transfer:
  - cycle 11 shows CS=1, SCLK=CPOL, OUT_BUSY=0
  - no OUT_DONE
  - OUT_RECEIVE_DATA=0
- IN_START held high across a done:
  - second transfer starts in the done cycle
  - CS high for exactly 1 cycle
  - two OUT_DONE pulses 35 cycles apart (N=8, H=2)

Source files
------------

// File: rtl/spi_fpga_pkg.sv
// Shared definitions for the SPI_FPGA master/slave family: FSM encoding,
// SCLK edge-type constants and the bit-reversal helper.
package spi_fpga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Edge type as seen on bit 0 of the edge counter (first edge is leading).
  localparam logic EDGE_LEADING  = 1'b0;
  localparam logic EDGE_TRAILING = 1'b1;

  // Widest word flip_backwards handles; callers zero-extend and truncate.
  localparam int unsigned FLIP_MAX   = 64;
  localparam int unsigned FLIP_IDX_W = 6;

  // Reverse the order of the low 'width' bits of 'value'; upper bits return 0.
  function automatic logic [FLIP_MAX-1:0] flip_backwards(
    input logic [FLIP_MAX-1:0] value,
    input int unsigned         width
  );
    logic [FLIP_MAX-1:0] result;
    result = '0;
    for (int unsigned i = 0; i < FLIP_MAX; i++) begin
      if (i < width) begin
        result[FLIP_IDX_W'(i)] = value[FLIP_IDX_W'(width - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_fpga_sclk_gen.sv
// SCLK timing for the SPI master: half-period divider producing a tick every
// CLK_DIV cycles while active, and an edge counter classifying each SCLK edge.
module spi_fpga_sclk_gen
  import spi_fpga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned PACK_LENGTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic shifting,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_edge
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGES  = 2 * PACK_LENGTH;
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              edge_stb;

  // Half-period counter, restarted whenever the master is idle.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Count SCLK edges issued in the current transfer.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      edge_cnt <= '0;
    end else if (edge_stb) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Tick, edge strobes and last-edge flag decoded from the counters.
  always_comb begin
    tick      = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    edge_stb  = tick && shifting;
    lead_stb  = edge_stb && (edge_cnt[0] == EDGE_LEADING);
    trail_stb = edge_stb && (edge_cnt[0] == EDGE_TRAILING);
    last_edge = (edge_cnt == EDGE_W'(EDGES - 1));
  end

endmodule

// File: rtl/spi_fpga_master.sv
// SPI master for the SPI_FPGA family: one start strobe launches one word
// transfer in any CPHA/CPOL mode; the received word is published with a
// single-cycle done pulse.
module spi_fpga_master
  import spi_fpga_pkg::*;
#(
  parameter int unsigned CPHA                       = 0,
  parameter int unsigned CPOL                       = 0,
  parameter int unsigned PACK_LENGTH                = 8,
  parameter int unsigned PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int unsigned CLK_DIV                    = 2
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET,
  input  logic                   IN_START,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   MISO,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic                   CS,
  output logic                   OUT_BUSY,
  output logic                   OUT_DONE,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA
);

  localparam int unsigned N         = PACK_LENGTH;
  localparam logic        IDLE_SCLK = (CPOL != 0);

  state_t         state;
  state_t         state_next;
  logic           tick;
  logic           lead_stb;
  logic           trail_stb;
  logic           last_edge;
  logic           run;
  logic           shifting;
  logic           accept;
  logic           finish;
  logic           drive_stb;
  logic           sample_stb;
  logic [N-1:0]   tx_reg;
  logic [N-1:0]   rx_reg;
  logic [N-1:0]   tx_load;
  logic [N-1:0]   rx_word;

  spi_fpga_sclk_gen #(
    .CLK_DIV     (CLK_DIV),
    .PACK_LENGTH (PACK_LENGTH)
  ) u_sclk_gen (
    .clk       (IN_CLK),
    .reset     (IN_RESET),
    .run       (run),
    .shifting  (shifting),
    .tick      (tick),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge)
  );

  // FSM state register.
  always_ff @(posedge IN_CLK) begin
    if (IN_RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; the tick ending SETUP is itself the first leading edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (IN_START) state_next = SETUP;
      SETUP:    if (tick) state_next = TRANSFER;
      TRANSFER: if (trail_stb && last_edge) state_next = HOLD;
      HOLD:     if (tick) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs and phase-dependent drive/sample selection.
  always_comb begin
    run        = (state != IDLE);
    shifting   = (state == SETUP) || (state == TRANSFER);
    accept     = (state == IDLE) && IN_START;
    finish     = (state == HOLD) && tick;
    OUT_BUSY   = run;
    drive_stb  = (CPHA == 0) ? (trail_stb && !last_edge) : lead_stb;
    sample_stb = (CPHA == 0) ? lead_stb : trail_stb;
  end

  // Bit-order adaptation of the transmit and receive words.
  always_comb begin
    tx_load = (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? IN_TRANSMIT_DATA
            : N'(flip_backwards(FLIP_MAX'(IN_TRANSMIT_DATA), N));
    rx_word = (PACK_BIT_SEQUENCE_RECEIVE != 0) ? rx_reg
            : N'(flip_backwards(FLIP_MAX'(rx_reg), N));
  end

  // Pin registers and shift registers.
  always_ff @(posedge IN_CLK) begin
    if (IN_RESET) begin
      CS               <= 1'b1;
      SCLK             <= IDLE_SCLK;
      MOSI             <= 1'b0;
      OUT_DONE         <= 1'b0;
      OUT_RECEIVE_DATA <= '0;
      tx_reg           <= '0;
      rx_reg           <= '0;
    end else begin
      OUT_DONE <= finish;
      if (accept) begin
        CS     <= 1'b0;
        // With CPHA=0 the first bit goes out on entry, so the register is
        // preloaded one position ahead; every later drive takes its MSB.
        MOSI   <= (CPHA == 0) ? tx_load[N-1] : 1'b0;
        tx_reg <= (CPHA == 0) ? {tx_load[N-2:0], 1'b0} : tx_load;
        rx_reg <= '0;
      end
      if (lead_stb || trail_stb) begin
        SCLK <= ~SCLK;
      end
      if (drive_stb) begin
        MOSI   <= tx_reg[N-1];
        tx_reg <= {tx_reg[N-2:0], 1'b0};
      end
      if (sample_stb) begin
        rx_reg <= {rx_reg[N-2:0], MISO};
      end
      if (finish) begin
        CS               <= 1'b1;
        MOSI             <= 1'b0;
        OUT_RECEIVE_DATA <= rx_word;
      end
    end
  end

endmodule

// File: tb/tb_spi_fpga_master.sv
// Scoreboard bench for spi_fpga_master: three instances in different modes,
// each with its own expectation queue and done-driven monitor.
module tb_spi_fpga_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  cap;
    logic        first;
    int unsigned at;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t c_q[$];

  logic rst = 1'b1;

  // A: mode 0, MSB/MSB, H=2, MISO looped to MOSI
  logic       a_start = 1'b0;
  logic [7:0] a_tx = '0;
  logic       a_sclk, a_mosi, a_cs, a_busy, a_done;
  logic [7:0] a_rx;
  // B: mode 3, MSB/MSB, H=2, behavioural slave
  logic       b_start = 1'b0;
  logic [7:0] b_tx = '0;
  logic       b_miso = 1'b0;
  logic       b_sclk, b_mosi, b_cs, b_busy, b_done;
  logic [7:0] b_rx;
  // C: CPHA=1 CPOL=0, LSB/LSB, H=3, loopback
  logic       c_start = 1'b0;
  logic [7:0] c_tx = '0;
  logic       c_sclk, c_mosi, c_cs, c_busy, c_done;
  logic [7:0] c_rx;

  spi_fpga_master #(.CPHA(0), .CPOL(0), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(1),
                    .PACK_BIT_SEQUENCE_RECEIVE(1), .CLK_DIV(2)) u_a (
    .IN_CLK(clk), .IN_RESET(rst), .IN_START(a_start), .IN_TRANSMIT_DATA(a_tx), .MISO(a_mosi),
    .SCLK(a_sclk), .MOSI(a_mosi), .CS(a_cs), .OUT_BUSY(a_busy), .OUT_DONE(a_done),
    .OUT_RECEIVE_DATA(a_rx));

  spi_fpga_master #(.CPHA(1), .CPOL(1), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(1),
                    .PACK_BIT_SEQUENCE_RECEIVE(1), .CLK_DIV(2)) u_b (
    .IN_CLK(clk), .IN_RESET(rst), .IN_START(b_start), .IN_TRANSMIT_DATA(b_tx), .MISO(b_miso),
    .SCLK(b_sclk), .MOSI(b_mosi), .CS(b_cs), .OUT_BUSY(b_busy), .OUT_DONE(b_done),
    .OUT_RECEIVE_DATA(b_rx));

  spi_fpga_master #(.CPHA(1), .CPOL(0), .PACK_LENGTH(8), .PACK_BIT_SEQUENCE_TRANSMIT(0),
                    .PACK_BIT_SEQUENCE_RECEIVE(0), .CLK_DIV(3)) u_c (
    .IN_CLK(clk), .IN_RESET(rst), .IN_START(c_start), .IN_TRANSMIT_DATA(c_tx), .MISO(c_mosi),
    .SCLK(c_sclk), .MOSI(c_mosi), .CS(c_cs), .OUT_BUSY(c_busy), .OUT_DONE(c_done),
    .OUT_RECEIVE_DATA(c_rx));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  // A: record MOSI on every rising SCLK (mode 0 sampling edge) and check each done.
  logic        a_sclk_q = 1'b0;
  logic        a_cs_q = 1'b1;
  logic [7:0]  a_cap = '0;
  int unsigned a_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!a_cs && a_cs_q) a_cap = '0;
    if (a_sclk && !a_sclk_q) a_cap = {a_cap[6:0], a_mosi};
    if (!a_cs) a_run++;
    if (a_done) begin
      if (a_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = a_q.pop_front();
        check("a_rx", 32'(a_rx), 32'(e.rx));
        check("a_mosi_bits", 32'(a_cap), 32'(e.cap));
        check("a_done_cycle", cyc, e.at);
        check("a_cs_low_cycles", a_run, 34);
        check("a_busy_at_done", 32'(a_busy), 0);
        check("a_cs_at_done", 32'(a_cs), 1);
        check("a_mosi_idle", 32'(a_mosi), 0);
      end
    end
    if (a_cs) a_run = 0;
    a_sclk_q = a_sclk;
    a_cs_q = a_cs;
  end

  // B: mode-3 slave shifting out its word MSB first, capturing MOSI on rising SCLK.
  logic       b_sclk_q = 1'b1;
  logic       b_cs_q = 1'b1;
  logic [7:0] b_slv_word = '0;
  logic [7:0] b_slv_cap = '0;
  logic [2:0] b_idx = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!b_cs && b_cs_q) begin
      b_idx = 3'd7;
      b_slv_cap = '0;
    end
    if (!b_cs && b_sclk_q && !b_sclk) begin
      b_miso = b_slv_word[b_idx];
      b_idx = b_idx - 3'd1;
    end
    if (!b_cs && !b_sclk_q && b_sclk) b_slv_cap = {b_slv_cap[6:0], b_mosi};
    if (b_done) begin
      if (b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = b_q.pop_front();
        check("b_rx", 32'(b_rx), 32'(e.rx));
        check("b_slave_capture", 32'(b_slv_cap), 32'(e.cap));
        check("b_done_cycle", cyc, e.at);
        check("b_sclk_idle_after", 32'(b_sclk), 1);
      end
    end
    b_sclk_q = b_sclk;
    b_cs_q = b_cs;
  end

  // C: record MOSI on every falling SCLK (CPHA=1, CPOL=0 sampling edge).
  logic        c_sclk_q = 1'b0;
  logic        c_cs_q = 1'b1;
  logic [7:0]  c_cap = '0;
  logic        c_first = 1'b0;
  int unsigned c_nbits = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!c_cs && c_cs_q) begin
      c_cap = '0;
      c_nbits = 0;
    end
    if (c_sclk_q && !c_sclk) begin
      if (c_nbits == 0) c_first = c_mosi;
      c_cap = {c_cap[6:0], c_mosi};
      c_nbits++;
    end
    if (c_done) begin
      if (c_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL c_unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = c_q.pop_front();
        check("c_rx", 32'(c_rx), 32'(e.rx));
        check("c_mosi_bits", 32'(c_cap), 32'(e.cap));
        check("c_first_mosi", 32'(c_first), 32'(e.first));
        check("c_done_cycle", cyc, e.at);
        check("c_sclk_idle_after", 32'(c_sclk), 0);
      end
    end
    c_sclk_q = c_sclk;
    c_cs_q = c_cs;
  end

  // Stimulus: each start pushes what the transfer must produce, then waits.
  task automatic start_a(input logic [7:0] w, input bit expect_done);
    a_tx = w;
    a_start = 1'b1;
    if (expect_done) a_q.push_back('{rx: w, cap: w, first: w[7], at: cyc + 35});
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] w, input logic [7:0] s);
    b_tx = w;
    b_slv_word = s;
    b_start = 1'b1;
    b_q.push_back('{rx: s, cap: w, first: w[7], at: cyc + 35});
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic start_c(input logic [7:0] w);
    c_tx = w;
    c_start = 1'b1;
    c_q.push_back('{rx: w, cap: rev8(w), first: w[0], at: cyc + 52});
    @(negedge clk);
    c_start = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int         waited;

    repeat (2) @(negedge clk);
    check("a_rst_cs", 32'(a_cs), 1);
    check("a_rst_sclk", 32'(a_sclk), 0);
    check("a_rst_mosi", 32'(a_mosi), 0);
    check("a_rst_busy", 32'(a_busy), 0);
    check("a_rst_done", 32'(a_done), 0);
    check("a_rst_rx", 32'(a_rx), 0);
    check("b_rst_sclk", 32'(b_sclk), 1);
    check("b_rst_cs", 32'(b_cs), 1);
    check("c_rst_sclk", 32'(c_sclk), 0);
    check("c_rst_rx", 32'(c_rx), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A: directed 0xA5, then random words with random idle gaps.
    start_a(8'hA5, 1'b1);
    repeat (36) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_a(8'($urandom), 1'b1);
      repeat (35 + $urandom_range(0, 3)) @(negedge clk);
    end

    // A: starts at cycles 5 and 20 of an active transfer must be ignored.
    w = 8'($urandom);
    start_a(w, 1'b1);
    repeat (4) @(negedge clk);
    check("a_busy_mid", 32'(a_busy), 1);
    a_tx = ~w;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (14) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_tx = w;
    repeat (20) @(negedge clk);

    // A: reset at cycle 10 of a transfer; nothing may be published.
    w = 8'($urandom) | 8'h01;
    start_a(w, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("a_reset_cs", 32'(a_cs), 1);
    check("a_reset_sclk", 32'(a_sclk), 0);
    check("a_reset_busy", 32'(a_busy), 0);
    check("a_reset_done", 32'(a_done), 0);
    check("a_reset_rx", 32'(a_rx), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // A: start held across a done gives a back-to-back transfer.
    w = 8'($urandom);
    w2 = 8'($urandom);
    a_tx = w;
    a_start = 1'b1;
    a_q.push_back('{rx: w, cap: w, first: w[7], at: cyc + 35});
    a_q.push_back('{rx: w2, cap: w2, first: w2[7], at: cyc + 70});
    @(negedge clk);
    a_tx = w2;
    waited = 0;
    while (!a_done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!a_done) begin
      tests++; fails++;
      $display("FAIL a_b2b_timeout: got no done in %0d cycles, required one", waited);
    end else begin
      check("a_b2b_cs_high", 32'(a_cs), 1);
    end
    @(negedge clk);
    a_start = 1'b0;
    check("a_b2b_cs_low_again", 32'(a_cs), 0);
    repeat (40) @(negedge clk);

    // B: directed 0xC3 against slave word 0x3C, then random pairs.
    check("b_sclk_idle_before", 32'(b_sclk), 1);
    start_b(8'hC3, 8'h3C);
    repeat (36) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_b(8'($urandom), 8'($urandom));
      repeat (35 + $urandom_range(0, 3)) @(negedge clk);
    end

    // C: directed 0x01, then random words.
    start_c(8'h01);
    repeat (53) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_c(8'($urandom));
      repeat (52 + $urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("a_pending", 32'(a_q.size()), 0);
    check("b_pending", 32'(b_q.size()), 0);
    check("c_pending", 32'(c_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
